// File: rtl/alu_issue_queue.sv
// alu_issue_queue: queues ALU ops, issues them one at a time to an external ALU, holds each result for downstream.
// Latency: m_valid rises ALU_LAT+1 cycles after the issue cycle (MUL_LAT+1 for MODE=1 CMD 9/10).
// Backpressure: s_ready drops while the queue is full; m_ready=0 holds the result and stalls further issue.
module alu_issue_queue #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  // upstream
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_opa,
  input  logic [WIDTH-1:0]       s_opb,
  input  logic [CMD_WIDTH-1:0]   s_cmd,
  input  logic                   s_cin,
  input  logic                   s_mode,
  input  logic [1:0]             s_inp_valid,
  // ALU drive
  output logic [WIDTH-1:0]       OPA,
  output logic [WIDTH-1:0]       OPB,
  output logic [CMD_WIDTH-1:0]   CMD,
  output logic                   CIN,
  output logic                   MODE,
  output logic [1:0]             IN_VALID,
  output logic                   CE,
  // ALU return
  input  logic [2*WIDTH-1:0]     RES,
  input  logic                   COUT,
  input  logic                   OFLOW,
  input  logic                   ERR,
  input  logic                   G,
  input  logic                   E,
  input  logic                   L,
  // downstream
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [2*WIDTH-1:0]     m_res,
  output logic [5:0]             m_flags,
  output logic [7:0]             m_tag,
  output logic                   busy
);

  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int LW      = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  typedef struct packed {
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [CMD_WIDTH-1:0] cmd;
    logic                 cin;
    logic                 mode;
    logic [1:0]           inp_valid;
    logic [7:0]           tag;
  } entry_t;

  entry_t               mem [DEPTH];
  entry_t               head;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [7:0]           tag_cnt;
  logic [1:0]           state;
  logic [LW-1:0]        wait_cnt;
  logic                 push;
  logic                 pop;
  logic                 is_mul;
  logic                 issuing;
  // last values presented to the ALU, held between issues
  logic [WIDTH-1:0]     opa_q;
  logic [WIDTH-1:0]     opb_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 cin_q;
  logic                 mode_q;

  // s_ready looks only at the registered count, so a same-cycle pop never reopens a full queue
  assign s_ready = (count < CW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign issuing = (state == ISSUE);
  assign pop     = issuing;
  assign head    = mem[rd_ptr];
  assign is_mul  = head.mode && ((head.cmd == CMD_WIDTH'(9)) || (head.cmd == CMD_WIDTH'(10)));

  assign OPA      = issuing ? head.opa       : opa_q;
  assign OPB      = issuing ? head.opb       : opb_q;
  assign CMD      = issuing ? head.cmd       : cmd_q;
  assign CIN      = issuing ? head.cin       : cin_q;
  assign MODE     = issuing ? head.mode      : mode_q;
  assign IN_VALID = issuing ? head.inp_valid : 2'b00;
  assign CE       = ~RST;
  assign m_valid  = (state == HOLD);
  assign busy     = (state != IDLE) || (count != '0);

  // entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {s_opa, s_opb, s_cmd, s_cin, s_mode, s_inp_valid, tag_cnt};
  end

  // queue pointers, occupancy and push tag counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        tag_cnt <= tag_cnt + 8'd1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // issue FSM: one op in flight, result captured when the latency counter expires
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      m_res    <= '0;
      m_flags  <= '0;
      m_tag    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cmd_q    <= '0;
      cin_q    <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) state <= ISSUE;
        end
        ISSUE: begin
          opa_q    <= head.opa;
          opb_q    <= head.opb;
          cmd_q    <= head.cmd;
          cin_q    <= head.cin;
          mode_q   <= head.mode;
          m_tag    <= head.tag;
          wait_cnt <= is_mul ? LW'(MUL_LAT) : LW'(ALU_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          // <= 1 also covers a zero latency setting instead of wrapping the counter
          if (wait_cnt <= LW'(1)) begin
            m_res    <= RES;
            m_flags  <= {COUT, E, G, L, OFLOW, ERR};
            wait_cnt <= '0;
            state    <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (m_ready) state <= (count != '0) ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 8, ALU operand width.
REQ-002 SHALL have parameter CMD_WIDTH, default 4, ALU command width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of 2).
REQ-004 SHALL have parameter ALU_LAT, default 1, ALU result latency in cycles for non-multiply commands.
REQ-005 SHALL have parameter MUL_LAT, default 2, ALU result latency for MODE=1 with CMD 9 or 10.
REQ-006 One clock; reset is asynchronous and active-high. Ports: CLK in 1, rising-edge clock; RST in 1, async active-high reset.
REQ-007 Upstream ports: s_valid in 1; s_ready out 1; s_opa in WIDTH; s_opb in WIDTH; s_cmd in CMD_WIDTH; s_cin in 1; s_mode in 1; s_inp_valid in 2.
REQ-008 ALU-drive ports: OPA out WIDTH; OPB out WIDTH; CMD out CMD_WIDTH; CIN out 1; MODE out 1; IN_VALID out 2; CE out 1.
REQ-009 ALU-return ports: RES in 2*WIDTH; COUT, OFLOW, ERR, G, E, L in 1 each.
REQ-010 Downstream ports: m_valid out 1; m_ready in 1; m_res out 2*WIDTH; m_flags out 6 as {COUT,E,G,L,OFLOW,ERR}; m_tag out 8; busy out 1.

Function
REQ-011 Queue SHALL store {opa,opb,cmd,cin,mode,inp_valid,tag}; push on s_valid && s_ready.
REQ-012 s_ready SHALL equal (count < DEPTH), derived from registered count only; a pop in the same cycle does not raise s_ready when full.
REQ-013 Tag SHALL be an 8-bit counter assigned at push, incremented per push, wrapping 255 -> 0.
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-015 IDLE -> ISSUE when count > 0; otherwise stay.
REQ-016 ISSUE (one cycle): drive OPA/OPB/CMD/CIN/MODE/IN_VALID from head entry, pop head, latch its tag, load wait counter with MUL_LAT if mode=1 and cmd in {9,10} else ALU_LAT; -> WAIT.
REQ-017 WAIT: decrement wait counter each cycle; at the edge where counter==1, register RES and flags into m_res/m_flags; -> HOLD.
REQ-018 HOLD: m_valid=1; m_res/m_flags/m_tag SHALL stay stable until m_ready=1; on m_ready -> ISSUE if count > 0, else IDLE.
REQ-019 Outside ISSUE, IN_VALID SHALL be 2'b00 and OPA/OPB/CMD/CIN/MODE SHALL hold last driven values.
REQ-020 CE SHALL be 1 in every cycle when RST is low.
REQ-021 Entries with inp_valid=2'b00 SHALL be issued normally; ALU ERR passes to m_flags unmodified.
REQ-022 Exactly one operation in flight; m_valid asserts ALU_LAT+1 (or MUL_LAT+1) cycles after the ISSUE cycle.
REQ-023 busy SHALL be 1 whenever state != IDLE or count > 0.
REQ-024 Pushes SHALL be accepted in any FSM state, including the same cycle as a pop.

Reset
REQ-025 On RST: state=IDLE, count=0, pointers=0, tag=0, wait counter=0, m_valid=0, m_res=0, m_flags=0, m_tag=0, OPA/OPB/CMD/CIN/MODE=0, IN_VALID=0, CE=0, busy=0.
REQ-026 RST asserted mid-WAIT or mid-HOLD SHALL discard the in-flight result and all queued entries; no m_valid after release until a new push completes.
REQ-027 First push after reset release SHALL carry tag 0.

Verification
REQ-028 Push MODE=1 CMD=0 OPA=8'h0F OPB=8'h01 CIN=0 inp_valid=11, m_ready=1 -> m_res=16'h0010, m_tag=0, m_valid at ISSUE+2 cycles, held one cycle.
REQ-029 Push MODE=1 CMD=9 OPA=3 OPB=4 inp_valid=11 -> m_res=16'h0014, m_valid at ISSUE+3 cycles.
REQ-030 m_ready=0, s_valid=1 continuously -> exactly 5 pushes accepted (1 in HOLD + 4 queued), then s_ready=0; m_res/m_tag stable throughout.
REQ-031 RST pulse during WAIT of tag 2 -> m_valid stays 0, busy=0, s_ready=1; next push gets tag 0.
REQ-032 300 back-to-back pushes with m_ready=1 -> m_tag sequence 0..255,0..43 in order, no drops or duplicates.
REQ-033 Push MODE=1 CMD=0 inp_valid=00 -> issued with IN_VALID=00; m_flags[0] equals ALU ERR.
